// File: rtl/key_pulse_if.sv
// Key-conditioning bus: raw key level in, count-enable strobe and debounced level out.
interface key_pulse_if;
    logic key_in;
    logic pulse_out;
    logic pressed;

    modport master (output key_in, input pulse_out, input pressed);
    modport slave  (input key_in, output pulse_out, output pressed);
endinterface

// File: rtl/key_pulse.sv
// Synchronises, debounces and edge-detects a raw key into a single-cycle count-enable
// pulse, with optional auto-repeat while held, plus the debounced key level.
module key_pulse #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter bit REPEAT_EN       = 1'b1,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 16,
    parameter int CNT_W           = 8
) (
    input  logic        clk,
    input  logic        reset,
    key_pulse_if.slave  bus,
    output logic [1:0]  state_dbg
);
    // pulse_out is a one-cycle strobe with no ready/backpressure: the consumer must
    // accept it in the cycle it is high.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    state_t           state;
    logic             sync1;
    logic             sync2;
    logic             key_s;
    logic [CNT_W-1:0] deb_cnt;
    logic [CNT_W-1:0] rpt_cnt;
    logic [CNT_W-1:0] rpt_last;
    logic             first_rep;
    logic             pulse_r;
    logic             pressed_r;

    assign key_s         = sync2;
    // The first repeat waits the long delay; later ones use the shorter period.
    assign rpt_last      = first_rep ? DELAY_LAST : PERIOD_LAST;
    assign bus.pulse_out = pulse_r;
    assign bus.pressed   = pressed_r;
    assign state_dbg     = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            state     <= IDLE;
            deb_cnt   <= '0;
            rpt_cnt   <= '0;
            pulse_r   <= 1'b0;
            pressed_r <= 1'b0;
            first_rep <= 1'b1;
        end else begin
            sync1   <= bus.key_in;
            sync2   <= sync1;
            pulse_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (key_s) begin
                        state   <= PRESS_CHK;
                        deb_cnt <= '0;
                    end
                end
                PRESS_CHK: begin
                    if (!key_s) begin
                        state <= IDLE;
                    end else if (deb_cnt == DEB_LAST) begin
                        state     <= HELD;
                        pulse_r   <= 1'b1;
                        pressed_r <= 1'b1;
                        rpt_cnt   <= '0;
                        first_rep <= 1'b1;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!key_s) begin
                        state   <= REL_CHK;
                        deb_cnt <= '0;
                    end else if (REPEAT_EN) begin
                        if (rpt_cnt == rpt_last) begin
                            pulse_r   <= 1'b1;
                            rpt_cnt   <= '0;
                            first_rep <= 1'b0;
                        end else begin
                            rpt_cnt <= rpt_cnt + 1'b1;
                        end
                    end else begin
                        rpt_cnt <= '0;
                    end
                end
                REL_CHK: begin
                    // A release bounce resumes the hold and restarts the repeat delay.
                    if (key_s) begin
                        state     <= HELD;
                        rpt_cnt   <= '0;
                        first_rep <= 1'b1;
                    end else if (deb_cnt == DEB_LAST) begin
                        state     <= IDLE;
                        pressed_r <= 1'b0;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_key_pulse.sv
// Directed bench for key_pulse: two instances (auto-repeat on and off) share one key;
// expected pulse edges are queued per scenario and popped as pulses appear.
module tb_key_pulse;
    logic       clk = 1'b0;
    logic       reset;
    logic       key;
    logic [1:0] state_a;
    logic [1:0] state_b;
    int         cyc = 0;
    int         base = 0;
    int         vectors = 0;
    int         miscompares = 0;
    logic [15:0] exp_a[$];
    logic [15:0] exp_b[$];

    key_pulse_if if_a ();
    key_pulse_if if_b ();

    assign if_a.key_in = key;
    assign if_b.key_in = key;

    key_pulse #(.DEBOUNCE_CYCLES(4), .REPEAT_EN(1'b1), .REPEAT_DELAY(8),
                .REPEAT_PERIOD(3), .CNT_W(8))
    dut_a (.clk(clk), .reset(reset), .bus(if_a.slave), .state_dbg(state_a));

    key_pulse #(.DEBOUNCE_CYCLES(4), .REPEAT_EN(1'b0), .REPEAT_DELAY(8),
                .REPEAT_PERIOD(3), .CNT_W(8))
    dut_b (.clk(clk), .reset(reset), .bus(if_b.slave), .state_dbg(state_b));

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench timed out");
    end

    function automatic int edge_now();
        return cyc - base;
    endfunction

    // scoreboard
    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, edge_now());
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (if_a.pulse_out === 1'b1) begin
            if (exp_a.size() == 0) check("unexpected pulse A", 16'(edge_now()), 16'hFFFF);
            else check("pulse A edge", 16'(edge_now()), exp_a.pop_front());
        end
        if (if_b.pulse_out === 1'b1) begin
            if (exp_b.size() == 0) check("unexpected pulse B", 16'(edge_now()), 16'hFFFF);
            else check("pulse B edge", 16'(edge_now()), exp_b.pop_front());
        end
    endtask

    task automatic run_to(input int e);
        while (edge_now() < e) tick();
    endtask

    task automatic check_pressed(input int e, input logic exp);
        run_to(e);
        check("pressed A", {15'd0, if_a.pressed}, {15'd0, exp});
        check("pressed B", {15'd0, if_b.pressed}, {15'd0, exp});
    endtask

    // driver: reset sampled at edges 0 and 1, key free from edge 2
    task automatic start_scen();
        reset = 1'b1;
        key   = 1'b0;
        base  = cyc + 1;
        run_to(1);
        check("reset pulse A", {15'd0, if_a.pulse_out}, 16'd0);
        check("reset pressed A", {15'd0, if_a.pressed}, 16'd0);
        check("reset state A", {14'd0, state_a}, 16'd0);
        check("reset state B", {14'd0, state_b}, 16'd0);
        reset = 1'b0;
    endtask

    task automatic end_scen(input int last_edge);
        run_to(last_edge);
        check("missing pulses A", 16'(exp_a.size()), 16'd0);
        check("missing pulses B", 16'(exp_b.size()), 16'd0);
        exp_a.delete();
        exp_b.delete();
    endtask

    initial begin
        reset = 1'b1;
        key   = 1'b0;
        @(negedge clk);

        // Clean press: key high for edges 2..11, released at edge 12.
        start_scen();
        exp_a.push_back(16'd8);
        exp_b.push_back(16'd8);
        key = 1'b1;
        check_pressed(7, 1'b0);
        check_pressed(8, 1'b1);
        check("held state A", {14'd0, state_a}, 16'd2);
        run_to(11);
        key = 1'b0;
        check_pressed(17, 1'b1);
        check_pressed(18, 1'b0);
        end_scen(25);

        // Bounce rejection: 1,0,1,0... for 8 samples, then 0.
        start_scen();
        for (int i = 0; i < 8; i++) begin
            key = (i % 2 == 0);
            run_to(2 + i);
        end
        key = 1'b0;
        check_pressed(6, 1'b0);
        check_pressed(12, 1'b0);
        check_pressed(20, 1'b0);
        end_scen(22);

        // Auto-repeat: key high for edges 2..21.
        start_scen();
        exp_a.push_back(16'd8);
        exp_a.push_back(16'd16);
        exp_a.push_back(16'd19);
        exp_a.push_back(16'd22);
        exp_b.push_back(16'd8);
        key = 1'b1;
        run_to(21);
        key = 1'b0;
        check_pressed(27, 1'b1);
        check_pressed(28, 1'b0);
        end_scen(32);

        // Release bounce: low at edges 10-11, back high, released at edge 30.
        start_scen();
        exp_a.push_back(16'd8);
        exp_a.push_back(16'd22);
        exp_a.push_back(16'd25);
        exp_a.push_back(16'd28);
        exp_a.push_back(16'd31);
        exp_b.push_back(16'd8);
        key = 1'b1;
        run_to(9);
        key = 1'b0;
        run_to(11);
        key = 1'b1;
        check_pressed(13, 1'b1);
        check_pressed(14, 1'b1);
        check_pressed(20, 1'b1);
        run_to(29);
        key = 1'b0;
        check_pressed(35, 1'b1);
        check_pressed(36, 1'b0);
        end_scen(40);

        // Long hold for 40 cycles: instance B pulses once, A keeps repeating.
        start_scen();
        exp_a.push_back(16'd8);
        for (int t = 16; t <= 43; t += 3) exp_a.push_back(16'(t));
        exp_b.push_back(16'd8);
        key = 1'b1;
        run_to(41);
        key = 1'b0;
        check_pressed(47, 1'b1);
        check_pressed(48, 1'b0);
        end_scen(55);

        // Reset at edge 12 with the key held: fresh press, pulse after edge 19.
        start_scen();
        exp_a.push_back(16'd8);
        exp_a.push_back(16'd19);
        exp_b.push_back(16'd8);
        exp_b.push_back(16'd19);
        key = 1'b1;
        check_pressed(11, 1'b1);
        reset = 1'b1;
        check_pressed(12, 1'b0);
        check("reset mid-hold pulse A", {15'd0, if_a.pulse_out}, 16'd0);
        check("reset mid-hold state A", {14'd0, state_a}, 16'd0);
        reset = 1'b0;
        check_pressed(18, 1'b0);
        check_pressed(19, 1'b1);
        run_to(24);
        key = 1'b0;
        end_scen(34);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
